// File: rtl/regfile_write_bank.sv
// Write side of the 32-entry integer register file: one-hot write decode, N-bit storage,
// flat register bus for the read selectors and per-register written-since-reset flags.
// Optional build macro REGFILE_ZERO_REG_EN hardwires register 31 (XZR) to zero.
module regfile_write_bank #(
  parameter int unsigned N = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [N-1:0]      wr_data,
  output logic [32*N-1:0]   q_flat,
  output logic [31:0]       written
);

  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;
`ifdef REGFILE_ZERO_REG_EN
  localparam int unsigned NSTORE = NREG - 1;
`else
  localparam int unsigned NSTORE = NREG;
`endif

  logic [NREG-1:0] en;

  // One-hot write decode; an unstored XZR never gets an enable.
  always_comb begin
    en = '0;
    for (int unsigned k = 0; k < NSTORE; k++) begin
      en[k] = wr_en && (wr_addr == AW'(k));
    end
  end

  for (genvar k = 0; k < int'(NSTORE); k++) begin : g_reg
    logic [N-1:0] r;

    always_ff @(posedge clk) begin
      if (reset) begin
        r <= '0;
      end else if (en[k]) begin
        r <= wr_data;
      end
    end

    assign q_flat[k*N +: N] = r;
  end

  if (NSTORE < NREG) begin : g_zero
    assign q_flat[(NREG-1)*N +: N] = '0;
  end

  // Sticky flags; bit 31 stays zero when XZR is hardwired since its enable never fires.
  always_ff @(posedge clk) begin
    if (reset) begin
      written <= '0;
    end else begin
      written <= written | en;
    end
  end

endmodule

// File: tb/tb_regfile_write_bank.sv
// Directed self-checking bench for regfile_write_bank; honours REGFILE_ZERO_REG_EN if defined.
module tb_regfile_write_bank;

  localparam int unsigned N = 64;
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic            clk;
  logic            reset;
  logic            wr_en;
  logic [4:0]      wr_addr;
  logic [N-1:0]    wr_data;
  logic [32*N-1:0] q_flat;
  logic [31:0]     written;

  int checks;
  int failures;

  regfile_write_bank #(.N(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .q_flat  (q_flat),
    .written (written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled on the following falling edge.
  task automatic test_reset();
    reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hFFFF;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int k = 0; k < 32; k++) begin
        checks++;
        if (q_flat[k*N +: N] !== 64'h0) begin
          failures++;
          $display("FAIL reset c%0d reg%0d: got %h exp 0", c, k, q_flat[k*N +: N]);
        end
      end
      checks++;
      if (written !== 32'h0) begin
        failures++;
        $display("FAIL reset_written c%0d: got %h exp 00000000", c, written);
      end
    end
    reset = 1'b0; wr_en = 1'b0;
  endtask

  task automatic test_single_write();
    logic [N-1:0] exp;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'hDEADBEEF_CAFEF00D;
    @(negedge clk);
    wr_en = 1'b0; wr_data = 64'h0;
    @(negedge clk);
    for (int k = 0; k < 32; k++) begin
      exp = (k == 3) ? 64'hDEADBEEF_CAFEF00D : 64'h0;
      checks++;
      if (q_flat[k*N +: N] !== exp) begin
        failures++;
        $display("FAIL single_write reg%0d: got %h exp %h", k, q_flat[k*N +: N], exp);
      end
    end
    checks++;
    if (written !== 32'h0000_0008) begin
      failures++;
      $display("FAIL single_write_written: got %h exp 00000008", written);
    end
  endtask

  task automatic test_walk();
    logic [N-1:0] exp;
    logic [31:0]  exp_w;
    exp_w = 32'h0000_0008;
    for (int k = 0; k < 32; k++) begin
      wr_en = 1'b1; wr_addr = 5'(k); wr_data = N'(k + 1);
      @(negedge clk);
      if (!(ZR && k == 31)) exp_w = exp_w | (32'h1 << k);
      exp = (ZR && k == 31) ? 64'h0 : N'(k + 1);
      checks++;
      if (q_flat[k*N +: N] !== exp) begin
        failures++;
        $display("FAIL walk_step reg%0d: got %h exp %h", k, q_flat[k*N +: N], exp);
      end
      checks++;
      if (written !== exp_w) begin
        failures++;
        $display("FAIL walk_step_written k%0d: got %h exp %h", k, written, exp_w);
      end
    end
    wr_en = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 32; k++) begin
      exp = (ZR && k == 31) ? 64'h0 : N'(k + 1);
      checks++;
      if (q_flat[k*N +: N] !== exp) begin
        failures++;
        $display("FAIL walk reg%0d: got %h exp %h", k, q_flat[k*N +: N], exp);
      end
    end
    exp_w = ZR ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
    checks++;
    if (written !== exp_w) begin
      failures++;
      $display("FAIL walk_written: got %h exp %h", written, exp_w);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] exp;
    for (int s = 1; s <= 2; s++) begin
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = N'(s);
      @(negedge clk);
      for (int k = 0; k < 32; k++) begin
        if (k == 7) exp = N'(s);
        else exp = (ZR && k == 31) ? 64'h0 : N'(k + 1);
        checks++;
        if (q_flat[k*N +: N] !== exp) begin
          failures++;
          $display("FAIL back_to_back s%0d reg%0d: got %h exp %h", s, k, q_flat[k*N +: N], exp);
        end
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic test_wr_en_low();
    logic [N-1:0] exp;
    for (int k = 0; k < 32; k++) begin
      wr_en = 1'b1; wr_addr = 5'(k); wr_data = N'(k + 1);
      @(negedge clk);
    end
    wr_en = 1'b0; wr_addr = 5'd9; wr_data = 64'h55;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int k = 0; k < 32; k++) begin
        exp = (ZR && k == 31) ? 64'h0 : N'(k + 1);
        checks++;
        if (q_flat[k*N +: N] !== exp) begin
          failures++;
          $display("FAIL wr_en_low c%0d reg%0d: got %h exp %h", c, k, q_flat[k*N +: N], exp);
        end
      end
      checks++;
      if (written !== (ZR ? 32'h7FFF_FFFF : 32'hFFFF_FFFF)) begin
        failures++;
        $display("FAIL wr_en_low_written c%0d: got %h", c, written);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] exp;
    reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd12; wr_data = 64'hAA;
    @(negedge clk);
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (q_flat[k*N +: N] !== 64'h0) begin
        failures++;
        $display("FAIL reset_mid reg%0d: got %h exp 0", k, q_flat[k*N +: N]);
      end
    end
    checks++;
    if (written !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_written: got %h exp 00000000", written);
    end
    reset = 1'b0; wr_en = 1'b1; wr_addr = 5'd12; wr_data = 64'hBB;
    @(negedge clk);
    wr_en = 1'b0;
    for (int k = 0; k < 32; k++) begin
      exp = (k == 12) ? 64'hBB : 64'h0;
      checks++;
      if (q_flat[k*N +: N] !== exp) begin
        failures++;
        $display("FAIL post_reset reg%0d: got %h exp %h", k, q_flat[k*N +: N], exp);
      end
    end
    checks++;
    if (written !== 32'h0000_1000) begin
      failures++;
      $display("FAIL post_reset_written: got %h exp 00001000", written);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1; wr_en = 1'b0; wr_addr = 5'd0; wr_data = '0;
    test_reset();
    test_single_write();
    test_walk();
    test_back_to_back();
    test_wr_en_low();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
